ovcam_axi_lite_master: RTL

Single-outstanding AXI4-Lite master that turns simple command/response requests into AXI4-Lite write and read transactions on the camera control register block. It sits between the capture/control logic and the camera's AXI4-Lite register slave:
- writes configure pixel coordinates and output select;
- reads poll pixel data and I2C-ready status.

A sticky watchdog flag reports any AXI channel that stalls beyond a programmable limit.

---
 rtl/ovcam_axi_lite_master_if.sv | 49 ++++
 rtl/ovcam_axi_lite_master.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ovcam_axi_lite_master_if.sv
// AXI4-Lite bus between the camera control master and the camera register slave.
interface ovcam_axi_lite_master_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]              M_AXI_AWPROT;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]              M_AXI_ARPROT;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_RREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_RREADY,
        output M_AXI_AWREADY, M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );
endinterface

// File: rtl/ovcam_axi_lite_master.sv
// Single-outstanding AXI4-Lite master for the camera control registers,
// with a sticky per-channel stall watchdog.
module ovcam_axi_lite_master #(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    busy,
    output logic                    timeout_err,
    input  logic                    timeout_clr,
    ovcam_axi_lite_master_if.master m_axi
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                    bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic [CNT_W-1:0]        wd_cnt_q, wd_cnt_d;
    logic                    timeout_err_q, timeout_err_d;
    logic                    waiting, wd_set;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? WADDR : RADDR;
                end
            end
            WADDR: begin
                if (awvalid_q && m_axi.M_AXI_AWREADY) aw_done_d = 1'b1;
                if (wvalid_q && m_axi.M_AXI_WREADY)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)            state_d   = WRESP;
            end
            WRESP: begin
                if (bready_q && m_axi.M_AXI_BVALID) begin
                    rsp_resp_d  = m_axi.M_AXI_BRESP;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RSP;
                end
            end
            RADDR: begin
                if (arvalid_q && m_axi.M_AXI_ARREADY) state_d = RDATA;
            end
            RDATA: begin
                if (rready_q && m_axi.M_AXI_RVALID) begin
                    rsp_resp_d  = m_axi.M_AXI_RRESP;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_axi.M_AXI_RDATA;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they land in flops
        // aligned with state_q, keeping AXI inputs off any output path.
        cmd_ready_d = (state_d == IDLE);
        awvalid_d   = (state_d == WADDR) && !aw_done_d;
        wvalid_d    = (state_d == WADDR) && !w_done_d;
        bready_d    = (state_d == WRESP);
        arvalid_d   = (state_d == RADDR);
        rready_d    = (state_d == RDATA);
        rsp_valid_d = (state_d == RSP);

        // Flag only on the transition into saturation so a clear during a
        // long stall is not immediately overridden.
        waiting = (state_q == WADDR) || (state_q == WRESP) ||
                  (state_q == RADDR) || (state_q == RDATA);
        if (state_d != state_q)                wd_cnt_d = '0;
        else if (waiting && wd_cnt_q != CNT_MAX) wd_cnt_d = wd_cnt_q + CNT_W'(1);
        else                                   wd_cnt_d = wd_cnt_q;
        wd_set        = (wd_cnt_d == CNT_MAX) && (wd_cnt_q != CNT_MAX);
        timeout_err_d = wd_set || (timeout_err_q && !timeout_clr);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = wstrb_q;
    assign m_axi.M_AXI_WVALID  = wvalid_q;
    assign m_axi.M_AXI_BREADY  = bready_q;
    assign m_axi.M_AXI_ARADDR  = addr_q;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;
endmodule
